// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Brief    : Blocking cache front-end. Loads hit in zero wait states and fill
//            the cache on a miss. Stores write through to SRAM and invalidate
//            the matching line.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [16:0] cache_addr,
    output logic [63:0] cache_wdata,
    output logic        cache_re,
    output logic        cache_we,
    output logic        cache_sram_we,
    input  logic        cache_hit,
    input  logic [31:0] cache_rdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ_MISS = 2'd1,
        S_WRITE     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        w_load;
    logic [16:0] w_in_idx;
    logic [16:0] w_lat_idx;

    // Subtracting 1024 from a byte address is subtracting 256 from its word index.
    assign w_in_idx  = address[18:2] - 17'd256;
    assign w_lat_idx = r_addr[18:2]  - 17'd256;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_load) begin
            r_addr  <= address;
            r_wdata <= wdata;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        ready         = 1'b1;
        rdata         = 32'd0;
        cache_addr    = w_in_idx;
        cache_wdata   = 64'd0;
        cache_re      = 1'b0;
        cache_we      = 1'b0;
        cache_sram_we = 1'b0;
        sram_r_en     = 1'b0;
        sram_w_en     = 1'b0;
        sram_addr     = 32'd0;
        sram_wdata    = 32'd0;

        // Reset silences every strobe immediately rather than at the next edge.
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (mem_w_en) begin
                        w_load        = 1'b1;
                        cache_sram_we = 1'b1;
                        sram_w_en     = 1'b1;
                        sram_addr     = address;
                        sram_wdata    = wdata;
                        ready         = 1'b0;
                        w_next_state  = S_WRITE;
                    end else if (mem_r_en) begin
                        if (cache_hit) begin
                            cache_re = 1'b1;
                            rdata    = cache_rdata;
                        end else begin
                            w_load       = 1'b1;
                            ready        = 1'b0;
                            w_next_state = S_READ_MISS;
                        end
                    end
                end
                S_READ_MISS: begin
                    cache_addr = w_lat_idx;
                    sram_addr  = r_addr;
                    if (sram_ready) begin
                        cache_we     = 1'b1;
                        cache_wdata  = sram_rdata;
                        rdata        = w_lat_idx[0] ? sram_rdata[63:32] : sram_rdata[31:0];
                        w_next_state = S_IDLE;
                    end else begin
                        sram_r_en = 1'b1;
                        ready     = 1'b0;
                    end
                end
                S_WRITE: begin
                    cache_addr    = w_lat_idx;
                    sram_w_en     = 1'b1;
                    cache_sram_we = 1'b1;
                    sram_addr     = r_addr;
                    sram_wdata    = r_wdata;
                    if (sram_ready) begin
                        w_next_state = S_IDLE;
                    end else begin
                        ready = 1'b0;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
